uv_ahb_to_apb: RTL and testbench

AHB-Lite slave to APB4 master bridge sitting directly downstream of the bus-to-AHB bridge: it consumes that block's AHB master outputs (single NONSEQ transfers, HBURST=SINGLE) and drives one APB4 peripheral segment. Each accepted AHB transfer becomes one APB SETUP/ACCESS sequence. The bridge holds the AHB data phase with HREADYOUT low until the APB transfer completes. It also converts PSLVERR or an APB timeout into a two-cycle AHB ERROR response.

---
 rtl/uv_ahb_to_apb_if.sv | 48 ++++
 rtl/uv_ahb_to_apb.sv | 158 +++++++++++++++
 tb/tb_uv_ahb_to_apb.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uv_ahb_to_apb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uv_ahb_to_apb_if                                                      |
// | AHB-Lite slave side and APB4 master side signals of the bridge.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface uv_ahb_to_apb_if #(
  parameter int ALEN = 12,
  parameter int DLEN = 32
);
  logic            ahb_hsel;
  logic [ALEN-1:0] ahb_haddr;
  logic [1:0]      ahb_htrans;
  logic [2:0]      ahb_hsize;
  logic [3:0]      ahb_hprot;
  logic            ahb_hwrite;
  logic [DLEN-1:0] ahb_hwdata;
  logic [DLEN-1:0] ahb_hrdata;
  logic            ahb_hreadyout;
  logic            ahb_hresp;
  logic            apb_psel;
  logic            apb_penable;
  logic [ALEN-1:0] apb_paddr;
  logic            apb_pwrite;
  logic [DLEN-1:0] apb_pwdata;
  logic [3:0]      apb_pstrb;
  logic [2:0]      apb_pprot;
  logic [DLEN-1:0] apb_prdata;
  logic            apb_pready;
  logic            apb_pslverr;

  // The bridge: AHB slave upstream, APB master downstream.
  modport slave (
    input  ahb_hsel, ahb_haddr, ahb_htrans, ahb_hsize, ahb_hprot, ahb_hwrite, ahb_hwdata,
    output ahb_hrdata, ahb_hreadyout, ahb_hresp,
    output apb_psel, apb_penable, apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_pprot,
    input  apb_prdata, apb_pready, apb_pslverr
  );

  // The surroundings: AHB master upstream, APB peripheral downstream.
  modport master (
    output ahb_hsel, ahb_haddr, ahb_htrans, ahb_hsize, ahb_hprot, ahb_hwrite, ahb_hwdata,
    input  ahb_hrdata, ahb_hreadyout, ahb_hresp,
    input  apb_psel, apb_penable, apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_pprot,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface
`default_nettype wire

// File: rtl/uv_ahb_to_apb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uv_ahb_to_apb                                                         |
// | AHB-Lite single-transfer slave to APB4 master bridge with timeout.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module uv_ahb_to_apb #(
  parameter int ALEN = 12,
  parameter int DLEN = 32,
  parameter int TOUT = 255
) (
  input  wire logic             clk,
  input  wire logic             rst,
  uv_ahb_to_apb_if.slave        io_bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [7:0] c_TOUT_LAST = 8'(TOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_hreadyout;
  logic            r_hresp;
  logic            r_psel;
  logic            r_penable;
  logic [ALEN-1:0] r_paddr;
  logic            r_pwrite;
  logic [3:0]      r_pstrb;
  logic [2:0]      r_pprot;
  logic [DLEN-1:0] r_wdata;
  logic [DLEN-1:0] r_hrdata;
  logic [7:0]      r_cnt;

  logic            w_accept;
  logic            w_tout;
  logic            w_hreadyout_nxt;
  logic            w_hresp_nxt;
  logic            w_psel_nxt;
  logic            w_penable_nxt;
  logic [3:0]      w_pstrb;

  // hreadyout stands in for the segment's HREADY input.
  assign w_accept = io_bus.ahb_hsel & io_bus.ahb_htrans[1] & r_hreadyout &
                    ((r_state == S_IDLE) | (r_state == S_RESP));

  always_comb begin
    w_pstrb = 4'h0;
    if (io_bus.ahb_hwrite) begin
      case (io_bus.ahb_hsize)
        3'd0:    w_pstrb = 4'b0001 << io_bus.ahb_haddr[1:0];
        3'd1:    w_pstrb = io_bus.ahb_haddr[1] ? 4'b1100 : 4'b0011;
        default: w_pstrb = 4'hF;
      endcase
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tout          = (TOUT != 0) && (r_cnt == c_TOUT_LAST);
    w_hreadyout_nxt = 1'b1;
    w_hresp_nxt     = 1'b0;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;

    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (io_bus.apb_pready) begin
          w_state_nxt = io_bus.apb_pslverr ? S_ERR1 : S_RESP;
        end else if (w_tout) begin
          w_state_nxt = S_ERR1;
        end
      end
      S_ERR1:   w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = w_accept ? S_SETUP : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (w_state_nxt)
      S_SETUP: begin
        w_hreadyout_nxt = 1'b0;
        w_psel_nxt      = 1'b1;
      end
      S_ACCESS: begin
        w_hreadyout_nxt = 1'b0;
        w_psel_nxt      = 1'b1;
        w_penable_nxt   = 1'b1;
      end
      S_ERR1: begin
        w_hreadyout_nxt = 1'b0;
        w_hresp_nxt     = 1'b1;
      end
      S_RESP:  w_hresp_nxt = (r_state == S_ERR1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pstrb     <= 4'h0;
      r_pprot     <= 3'b000;
      r_wdata     <= '0;
      r_hrdata    <= '0;
      r_cnt       <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      if (w_accept) begin
        r_paddr  <= io_bus.ahb_haddr;
        r_pwrite <= io_bus.ahb_hwrite;
        r_pstrb  <= w_pstrb;
        r_pprot  <= {~io_bus.ahb_hprot[0], 1'b0, io_bus.ahb_hprot[1]};
        r_cnt    <= 8'd0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == S_SETUP) begin
        r_wdata <= io_bus.ahb_hwdata;
      end
      if ((r_state == S_ACCESS) && io_bus.apb_pready && !r_pwrite) begin
        r_hrdata <= io_bus.apb_prdata;
      end
    end
  end

  assign io_bus.ahb_hrdata    = r_hrdata;
  assign io_bus.ahb_hreadyout = r_hreadyout;
  assign io_bus.ahb_hresp     = r_hresp;
  assign io_bus.apb_psel      = r_psel;
  assign io_bus.apb_penable   = r_penable;
  assign io_bus.apb_paddr     = r_paddr;
  assign io_bus.apb_pwrite    = r_pwrite;
  assign io_bus.apb_pstrb     = r_pstrb;
  assign io_bus.apb_pprot     = r_pprot;
  // Write data flows straight through in SETUP, then from the captured copy.
  assign io_bus.apb_pwdata    = (r_state == S_SETUP) ? io_bus.ahb_hwdata : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uv_ahb_to_apb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uv_ahb_to_apb                                                      |
// | Directed bench with a per-cycle transfer-timeline model of the bridge.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_uv_ahb_to_apb;
  localparam int TOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uv_ahb_to_apb_if #(.ALEN(12), .DLEN(32)) bif ();

  uv_ahb_to_apb #(.ALEN(12), .DLEN(32), .TOUT(TOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hr;
    logic        hresp;
    logic        psel;
    logic        pen;
    logic        attr;
    logic [11:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic        ld;
    logic [31:0] ldv;
  } rec_t;

  rec_t        exp_q [int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_on = 1'b0;
  logic [31:0] m_hrdata = 32'h0;
  int          rsp_wait = 0;
  bit          rsp_err = 1'b0;
  logic [31:0] rsp_rd = 32'h0;
  int          acc_i = 0;
  int          acc_cur = 0;
  int          acc_run = 0;

  always @(posedge clk) cyc++;

  function automatic rec_t idle_rec();
    rec_t r;
    r    = '0;
    r.hr = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, expv);
    end
  endtask

  // APB peripheral: raises pready on ACCESS cycle number rsp_wait (0-based).
  always @(negedge clk) begin
    if (bif.apb_psel && bif.apb_penable) begin
      bif.apb_pready  = (acc_i == rsp_wait);
      bif.apb_pslverr = bif.apb_pready && rsp_err;
      bif.apb_prdata  = bif.apb_pready ? rsp_rd : 32'h0;
      acc_i++;
    end else begin
      acc_i           = 0;
      bif.apb_pready  = 1'b0;
      bif.apb_pslverr = 1'b0;
      bif.apb_prdata  = 32'h0;
    end
  end

  // Per-cycle comparison against the timeline model.
  rec_t ce;
  always @(negedge clk) begin
    if (chk_on) begin
      ce = idle_rec();
      if (exp_q.exists(cyc)) ce = exp_q[cyc];
      if (ce.ld) m_hrdata = ce.ldv;
      chk("hreadyout", 32'(bif.ahb_hreadyout), 32'(ce.hr));
      chk("hresp",     32'(bif.ahb_hresp),     32'(ce.hresp));
      chk("psel",      32'(bif.apb_psel),      32'(ce.psel));
      chk("penable",   32'(bif.apb_penable),   32'(ce.pen));
      chk("hrdata",    bif.ahb_hrdata,         m_hrdata);
      if (ce.attr) begin
        chk("paddr",  32'(bif.apb_paddr),  32'(ce.paddr));
        chk("pwrite", 32'(bif.apb_pwrite), 32'(ce.pwrite));
        chk("pstrb",  32'(bif.apb_pstrb),  32'(ce.pstrb));
        chk("pprot",  32'(bif.apb_pprot),  32'(ce.pprot));
        if (ce.psel) chk("pwdata", bif.apb_pwdata, ce.pwdata);
      end
    end
    if (bif.apb_psel && bif.apb_penable) begin
      acc_cur++;
    end else if (acc_cur != 0) begin
      acc_run = acc_cur;
      acc_cur = 0;
    end
  end

  // Present one address phase in the current cycle and record its expected timeline.
  task automatic issue(input logic [11:0] a, input bit w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] prot, input int wt,
                       input bit er, input logic [31:0] rd, output int c_resp);
    int   c0;
    int   nacc;
    bit   to;
    rec_t r;
    c0   = cyc;
    to   = (TOUT != 0) && (wt >= TOUT);
    nacc = to ? TOUT : wt + 1;
    r        = idle_rec();
    r.attr   = 1'b1;
    r.paddr  = a;
    r.pwrite = w;
    if (!w)           r.pstrb = 4'h0;
    else if (sz == 0) r.pstrb = 4'(1 << (a & 12'd3));
    else if (sz == 1) r.pstrb = ((a & 12'd2) != 0) ? 4'hC : 4'h3;
    else              r.pstrb = 4'hF;
    r.pprot  = {~prot[0], 1'b0, prot[1]};
    r.pwdata = w ? wd : 32'h0;
    r.hr   = 1'b0;
    r.psel = 1'b1;
    exp_q[c0 + 1] = r;
    r.pen = 1'b1;
    for (int k = 0; k < nacc; k++) exp_q[c0 + 2 + k] = r;
    r.psel = 1'b0;
    r.pen  = 1'b0;
    r.ld   = !w && !to;
    r.ldv  = rd;
    if (to || er) begin
      r.hresp = 1'b1;
      exp_q[c0 + 2 + nacc] = r;
      r.ld = 1'b0;
      r.hr = 1'b1;
      exp_q[c0 + 3 + nacc] = r;
      c_resp = c0 + 3 + nacc;
    end else begin
      r.hr = 1'b1;
      exp_q[c0 + 2 + nacc] = r;
      c_resp = c0 + 2 + nacc;
    end
    rsp_wait       = wt;
    rsp_err        = er;
    rsp_rd         = rd;
    bif.ahb_hsel   = 1'b1;
    bif.ahb_htrans = 2'b10;
    bif.ahb_haddr  = a;
    bif.ahb_hwrite = w;
    bif.ahb_hsize  = sz;
    bif.ahb_hprot  = prot;
    @(posedge clk); #1;
    bif.ahb_hsel   = 1'b0;
    bif.ahb_htrans = 2'b00;
    bif.ahb_hwdata = w ? wd : 32'h0;
  endtask

  // Full transfer: returns just after the edge that opens its RESP cycle.
  task automatic xfer(input logic [11:0] a, input bit w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [3:0] prot, input int wt,
                      input bit er, input logic [31:0] rd, output int c_resp);
    issue(a, w, sz, wd, prot, wt, er, rd, c_resp);
    while (cyc < c_resp) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   cs;
    int   cr;
    int   cr1;
    int   cr2;
    rec_t r;
    bif.ahb_hsel   = 1'b0;
    bif.ahb_haddr  = 12'h0;
    bif.ahb_htrans = 2'b00;
    bif.ahb_hsize  = 3'd0;
    bif.ahb_hprot  = 4'h0;
    bif.ahb_hwrite = 1'b0;
    bif.ahb_hwdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", 32'(bif.ahb_hreadyout), 32'h1);
    chk("rst_hresp",     32'(bif.ahb_hresp),     32'h0);
    chk("rst_psel",      32'(bif.apb_psel),      32'h0);
    chk("rst_penable",   32'(bif.apb_penable),   32'h0);
    chk("rst_hrdata",    bif.ahb_hrdata,         32'h0);
    chk("rst_paddr",     32'(bif.apb_paddr),     32'h0);
    chk("rst_pstrb",     32'(bif.apb_pstrb),     32'h0);
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Word write, zero wait states.
    xfer(12'h010, 1'b1, 3'd2, 32'hA5A5_1234, 4'b0011, 0, 1'b0, 32'h0, cr);
    @(negedge clk);
    chk("w1_paddr", 32'(bif.apb_paddr), 32'h010);
    chk("w1_pstrb", 32'(bif.apb_pstrb), 32'hF);
    chk("w1_done",  32'({bif.ahb_hreadyout, bif.ahb_hresp}), 32'b10);
    @(posedge clk); #1;

    // Read with three wait states.
    cs = cyc;
    xfer(12'h020, 1'b0, 3'd2, 32'h0, 4'b0000, 3, 1'b0, 32'hDEAD_BEEF, cr);
    chk("r1_latency", 32'(cr - cs), 32'd6);
    @(negedge clk);
    chk("r1_hrdata", bif.ahb_hrdata, 32'hDEAD_BEEF);
    chk("r1_pstrb",  32'(bif.apb_pstrb), 32'h0);

    // Byte then halfword write, issued back to back.
    xfer(12'h003, 1'b1, 3'd0, 32'h1122_3344, 4'b0010, 0, 1'b0, 32'h0, cr);
    @(negedge clk);
    chk("byte_pstrb", 32'(bif.apb_pstrb), 32'b1000);
    xfer(12'h006, 1'b1, 3'd1, 32'h5566_7788, 4'b0010, 1, 1'b0, 32'h0, cr);
    @(negedge clk);
    chk("half_pstrb", 32'(bif.apb_pstrb), 32'b1100);

    // Slave error, then a clean transfer.
    issue(12'h040, 1'b0, 3'd2, 32'h0, 4'b0001, 0, 1'b1, 32'h0BAD_0BAD, cr);
    @(posedge clk); @(negedge clk); @(negedge clk);
    chk("err1_resp", 32'({bif.ahb_hreadyout, bif.ahb_hresp}), 32'b01);
    @(negedge clk);
    chk("err2_resp", 32'({bif.ahb_hreadyout, bif.ahb_hresp}), 32'b11);
    xfer(12'h044, 1'b1, 3'd2, 32'h0000_4444, 4'b0000, 1, 1'b0, 32'h0, cr);
    @(negedge clk);
    chk("after_err_resp", 32'({bif.ahb_hreadyout, bif.ahb_hresp}), 32'b10);

    // BUSY and unselected address phases must not start anything.
    @(posedge clk); #1;
    bif.ahb_hsel = 1'b1; bif.ahb_htrans = 2'b01;
    @(posedge clk); #1;
    bif.ahb_hsel = 1'b0; bif.ahb_htrans = 2'b10;
    @(posedge clk); #1;
    bif.ahb_htrans = 2'b00;
    @(posedge clk); #1;

    // Timeout, then a transfer showing the counter restarts.
    xfer(12'h080, 1'b1, 3'd2, 32'hCAFE_F00D, 4'b0000, 99, 1'b0, 32'h0, cr);
    repeat (2) @(negedge clk);
    chk("tout_access_cycles", 32'(acc_run), 32'd4);
    xfer(12'h084, 1'b0, 3'd2, 32'h0, 4'b0000, 2, 1'b0, 32'h1234_5678, cr);
    repeat (2) @(negedge clk);
    chk("after_tout_access", 32'(acc_run), 32'd3);
    @(posedge clk); #1;

    // Back-to-back reads, then a reset in the ACCESS of a third.
    xfer(12'h100, 1'b0, 3'd2, 32'h0, 4'b0000, 0, 1'b0, 32'h0101_0101, cr1);
    xfer(12'h104, 1'b0, 3'd2, 32'h0, 4'b0000, 0, 1'b0, 32'h0202_0202, cr2);
    chk("b2b_gap", 32'(cr2 - cr1), 32'd3);
    issue(12'h108, 1'b0, 3'd2, 32'h0, 4'b0000, 5, 1'b0, 32'h0303_0303, cr);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = cyc + 1; k <= cyc + 20; k++) begin
      if (exp_q.exists(k)) exp_q.delete(k);
    end
    r     = idle_rec();
    r.ld  = 1'b1;
    r.ldv = 32'h0;
    exp_q[cyc + 1] = r;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_psel",      32'(bif.apb_psel),      32'h0);
    chk("post_rst_hreadyout", 32'(bif.ahb_hreadyout), 32'h1);
    chk("post_rst_hrdata",    bif.ahb_hrdata,         32'h0);

    // Recovery after reset.
    @(posedge clk); #1;
    xfer(12'h00C, 1'b1, 3'd2, 32'h600D_F00D, 4'b0000, 0, 1'b0, 32'h0, cr);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
